// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the VDP 4x16 regfile: two requesters, round-robin with
// burst ownership, a beat cap and an idle-hold timeout; refreshes rd when idle.
module regfile_wr_arbiter #(
    parameter int MAX_BURST    = 4,
    parameter int HOLD_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [1:0]  req0_rd_i,
    input  logic [15:0] req0_data_i,
    input  logic        req0_last_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [1:0]  req1_rd_i,
    input  logic [15:0] req1_data_i,
    input  logic        req1_last_i,
    output logic        req1_ready_o,
    input  logic [15:0] r0_i,
    input  logic [15:0] r1_i,
    input  logic [15:0] r2_i,
    input  logic [15:0] r3_i,
    output logic [1:0]  rd_o,
    output logic [15:0] result_o,
    output logic        wr_strobe_o,
    output logic [1:0]  grant_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);

    // State encoding doubles as the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic           lru_q, lru_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [1:0]     rd_q;
    logic [15:0]    data_q;
    logic           strobe_q;

    logic           sel;
    logic           rdy0, rdy1;
    logic           accept;
    logic           sel_valid;
    logic           sel_last;
    logic [1:0]     sel_rd;
    logic [15:0]    sel_data;

    always_comb begin
        sel  = 1'b0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    // lru_q names the requester granted last; the other wins a tie.
                    sel  = (req0_valid_i && req1_valid_i) ? ~lru_q : req1_valid_i;
                    rdy0 = ~sel;
                    rdy1 = sel;
                end
            end
            OWN0: begin
                sel  = 1'b0;
                rdy0 = 1'b1;
            end
            OWN1: begin
                sel  = 1'b1;
                rdy1 = 1'b1;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
        if (rst_i) begin
            rdy0 = 1'b0;
            rdy1 = 1'b0;
        end
    end

    assign sel_valid = sel ? req1_valid_i : req0_valid_i;
    assign sel_last  = sel ? req1_last_i  : req0_last_i;
    assign sel_rd    = sel ? req1_rd_i    : req0_rd_i;
    assign sel_data  = sel ? req1_data_i  : req0_data_i;
    assign accept    = (rdy0 && req0_valid_i) || (rdy1 && req1_valid_i);

    always_comb begin
        state_d = state_q;
        lru_d   = lru_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_last || MAX_BURST == 1) begin
                        lru_d = sel;
                    end else begin
                        state_d = sel ? OWN1 : OWN0;
                        beat_d  = BW'(1);
                        hold_d  = '0;
                    end
                end
            end
            OWN0, OWN1: begin
                if (accept) begin
                    beat_d = beat_q + BW'(1);
                    hold_d = '0;
                    if (sel_last || beat_q == BW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        lru_d   = sel;
                        beat_d  = '0;
                    end
                end else if (!sel_valid) begin
                    hold_d = hold_q + HW'(1);
                    if (hold_q == HW'(HOLD_TIMEOUT - 1)) begin
                        state_d = IDLE;
                        lru_d   = sel;
                        beat_d  = '0;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lru_q    <= 1'b1;
            beat_q   <= '0;
            hold_q   <= '0;
            rd_q     <= 2'd0;
            data_q   <= 16'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lru_q   <= lru_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            if (accept) begin
                rd_q     <= sel_rd;
                data_q   <= sel_data;
                strobe_q <= 1'b1;
            end else begin
                strobe_q <= 1'b0;
            end
        end
    end

    // Reset masks a beat registered just before it, so the regfile only sees an r0 refresh.
    assign rd_o        = rst_i ? 2'd0 : rd_q;
    assign wr_strobe_o = strobe_q && !rst_i;

    always_comb begin
        result_o = r0_i;
        if (wr_strobe_o) begin
            result_o = data_q;
        end else begin
            case (rd_o)
                2'd0:    result_o = r0_i;
                2'd1:    result_o = r1_i;
                2'd2:    result_o = r2_i;
                default: result_o = r3_i;
            endcase
        end
    end

    assign req0_ready_o = rdy0;
    assign req1_ready_o = rdy1;
    assign grant_o      = state_q;

endmodule
